// File: rtl/dac_spi_serializer.sv
// Serializes 8-bit sine samples into 16-bit SPI frames for a 12-bit DAC.
// A one-entry hold buffer decouples the producer from the SPI frame timing.
module dac_spi_serializer #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 8,
    parameter int FRAME_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              dac_sync_n,
    output logic              dac_sclk,
    output logic              dac_din,
    output logic              busy,
    output logic              overrun
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int PAD_W = FRAME_W - 4 - DATA_W;
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] GAP_LAST  = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [3:0]       BIT_FIRST = 4'(FRAME_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic               hold_valid_q, hold_valid_d;
    logic               ready_q, ready_d;
    logic               overrun_q, overrun_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [3:0]         bit_q, bit_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               sync_q, sync_d;
    logic               sclk_q, sclk_d;
    logic               din_q, din_d;
    logic               busy_q, busy_d;
    logic [FRAME_W-1:0] frame;

    // Control nibble 0000 (normal mode), sample left-justified in the 12-bit code.
    assign frame = {4'b0000, hold_q, {PAD_W{1'b0}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            overrun_q    <= 1'b0;
            shreg_q      <= '0;
            bit_q        <= '0;
            div_q        <= '0;
            sync_q       <= 1'b1;
            sclk_q       <= 1'b1;
            din_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            ready_q      <= ready_d;
            overrun_q    <= overrun_d;
            shreg_q      <= shreg_d;
            bit_q        <= bit_d;
            div_q        <= div_d;
            sync_q       <= sync_d;
            sclk_q       <= sclk_d;
            din_q        <= din_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        overrun_d    = overrun_q;
        shreg_d      = shreg_q;
        bit_d        = bit_q;
        div_d        = div_q;
        sync_d       = sync_q;
        sclk_d       = sclk_q;
        din_d        = din_q;
        busy_d       = busy_q;

        unique case (state_q)
            IDLE: begin
                if (hold_valid_q) begin
                    hold_valid_d = 1'b0;
                    shreg_d      = frame;
                    din_d        = frame[FRAME_W-1];
                    sync_d       = 1'b0;
                    sclk_d       = 1'b1;
                    busy_d       = 1'b1;
                    bit_d        = BIT_FIRST;
                    div_d        = '0;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                if (div_q == HALF_LAST) begin
                    div_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                    end else if (bit_q == 4'd0) begin
                        sclk_d  = 1'b1;
                        sync_d  = 1'b1;
                        din_d   = 1'b0;
                        state_d = GAP;
                    end else begin
                        // DIN only moves together with the SCLK rising edge.
                        sclk_d  = 1'b1;
                        bit_d   = bit_q - 4'd1;
                        din_d   = shreg_q[FRAME_W-2];
                        shreg_d = shreg_q << 1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            GAP: begin
                if (div_q == GAP_LAST) begin
                    div_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // ready_q mirrors !hold_valid_q, so accept and drain never coincide.
        if (sample_valid) begin
            if (ready_q) begin
                hold_d       = sample_in;
                hold_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        ready_d = !hold_valid_d;
    end

    assign sample_ready = ready_q;
    assign dac_sync_n   = sync_q;
    assign dac_sclk     = sclk_q;
    assign dac_din      = din_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule
